// File: rtl/cluster_finding_pkg.sv
// Shared definitions for the cluster finding datapath: sizing helper, invalid address, limits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cluster_finding_pkg;

  // Largest number of results a single snapshot may yield (idx_o is 4 bits wide).
  localparam int MXOUT_MAX = 16;

  // Address reported when no result is present; wide enough for any MXKEYBITS in use.
  localparam logic [15:0] ADR_INVALID = 16'hFFFF;

  // Scanner state: waiting for a snapshot, or walking the captured mask.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_tree.sv
// Lowest-index set bit finder: returns {found, index, count} of the first valid pad.
// Latency: purely combinational, log2(pads) mux levels.
// Backpressure: none; output follows input every cycle.
module priority_tree
  import cluster_finding_pkg::*;
#(
  parameter int MXKEYS = 192,
  parameter int MXCNTB = 3
) (
  input  logic [MXKEYS-1:0]        vpfs,
  input  logic [MXKEYS*MXCNTB-1:0] cnts,
  output logic                     found,
  output logic [clog2(MXKEYS)-1:0] index,
  output logic [MXCNTB-1:0]        count
);

  localparam int IDXB = clog2(MXKEYS);
  localparam int NPAD = 1 << IDXB;

  // Inputs widened to a power of two; the extra pads are never valid.
  logic [NPAD-1:0]        vpf_pad;
  logic [NPAD*MXCNTB-1:0] cnt_pad;

  assign vpf_pad = NPAD'(vpfs);
  assign cnt_pad = (NPAD*MXCNTB)'(cnts);

  // Node storage, reused level by level: after level s, slots [0, NPAD>>s) hold that level.
  logic              node_f [NPAD];
  logic [IDXB-1:0]   node_i [NPAD];
  logic [MXCNTB-1:0] node_c [NPAD];

  // Binary reduction tree: each node keeps its left child when the left child found a bit,
  // so the lower index always wins. Slots are rewritten in ascending order, which only
  // overwrites entries the current level has already consumed.
  always_comb begin
    for (int i = 0; i < NPAD; i++) begin
      node_f[i] = vpf_pad[i];
      node_i[i] = IDXB'(i);
      node_c[i] = cnt_pad[i*MXCNTB +: MXCNTB];
    end
    for (int s = 1; s <= IDXB; s++) begin
      for (int j = 0; j < (NPAD >> s); j++) begin
        if (node_f[2*j]) begin
          node_i[j] = node_i[2*j];
          node_c[j] = node_c[2*j];
        end else begin
          node_i[j] = node_i[2*j+1];
          node_c[j] = node_c[2*j+1];
        end
        node_f[j] = node_f[2*j] | node_f[2*j+1];
      end
    end
  end

  assign found = node_f[0];
  assign index = node_i[0];
  assign count = node_c[0];

endmodule

// File: rtl/priority_multi.sv
// Snapshot scanner: captures pad flags/counts and emits up to MXOUT results in index order.
// Latency: accept at edge N, result k registered at edge N+1+k; one result per clock.
// Backpressure: ready_o low while scanning; start_i ignored until the done_o cycle.
module priority_multi
  import cluster_finding_pkg::*;
#(
  parameter int MXKEYS    = 192,
  parameter int MXKEYBITS = 8,
  parameter int MXCNTB    = 3,
  parameter int MXOUT     = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start_i,
  output logic                     ready_o,
  input  logic [2:0]               pass_i,
  input  logic [MXKEYS-1:0]        vpfs_i,
  input  logic [MXKEYS*MXCNTB-1:0] cnts_i,
  output logic                     vpf_o,
  output logic [MXKEYBITS-1:0]     adr_o,
  output logic [MXCNTB-1:0]        cnt_o,
  output logic [3:0]               idx_o,
  output logic [2:0]               pass_o,
  output logic                     done_o,
  output logic [4:0]               nfound_o,
  output logic                     overflow_o
);

  localparam int IDXB = clog2(MXKEYS);
  localparam logic [MXKEYBITS-1:0] ADR_INV = ADR_INVALID[MXKEYBITS-1:0];
  localparam logic [3:0]           K_LAST  = 4'(MXOUT - 1);

  // Reject parameter sets the datapath cannot represent.
  if ((1 << MXKEYBITS) < (MXKEYS + 1)) begin : g_bad_adr_width
    $error("priority_multi: MXKEYBITS too small for MXKEYS pads plus the invalid address");
  end
  if ((MXKEYS < 2) || (MXKEYS > 1536)) begin : g_bad_keys
    $error("priority_multi: MXKEYS out of range 2..1536");
  end
  if ((MXOUT < 1) || (MXOUT > MXOUT_MAX)) begin : g_bad_out
    $error("priority_multi: MXOUT out of range 1..16");
  end

  // Registered state
  scan_state_t              state_q, state_d;
  logic [MXKEYS-1:0]        mask_q, mask_d;
  logic [MXKEYS*MXCNTB-1:0] cnts_q, cnts_d;
  logic [2:0]               pass_q, pass_d;
  logic [3:0]               k_q, k_d;

  // Next values of the registered outputs
  logic                 vpf_d;
  logic [MXKEYBITS-1:0] adr_d;
  logic [MXCNTB-1:0]    cnt_d;
  logic [3:0]           idx_d;
  logic                 done_d;
  logic [4:0]           nfound_d;
  logic                 ovf_d;

  // Search result over the remaining mask
  logic              tree_found;
  logic [IDXB-1:0]   tree_idx;
  logic [MXCNTB-1:0] tree_cnt;
  logic [MXKEYS-1:0] pick_oh;
  logic [MXKEYS-1:0] mask_rem;
  logic              last_pick;

  priority_tree #(
    .MXKEYS (MXKEYS),
    .MXCNTB (MXCNTB)
  ) u_tree (
    .vpfs  (mask_q),
    .cnts  (cnts_q),
    .found (tree_found),
    .index (tree_idx),
    .count (tree_cnt)
  );

  // Mask after removing the bit being reported this cycle, and whether this pick ends the scan.
  always_comb begin
    pick_oh   = MXKEYS'(1) << tree_idx;
    mask_rem  = mask_q & ~pick_oh;
    last_pick = (mask_rem == '0) || (k_q == K_LAST);
  end

  assign ready_o = (state_q == ST_IDLE);

  // Next-state and output decode; strobes default low, result fields default to "no result".
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnts_d   = cnts_q;
    pass_d   = pass_q;
    k_d      = k_q;
    vpf_d    = 1'b0;
    adr_d    = ADR_INV;
    cnt_d    = '0;
    idx_d    = '0;
    done_d   = 1'b0;
    nfound_d = nfound_o;
    ovf_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mask_d  = vpfs_i;
          cnts_d  = cnts_i;
          pass_d  = pass_i;
          k_d     = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (tree_found) begin
          vpf_d  = 1'b1;
          adr_d  = MXKEYBITS'(tree_idx);
          cnt_d  = tree_cnt;
          idx_d  = k_q;
          k_d    = k_q + 4'd1;
          mask_d = mask_rem;
          if (last_pick) begin
            // Anything still set once the result budget is spent is dropped.
            done_d   = 1'b1;
            nfound_d = 5'(k_q) + 5'd1;
            ovf_d    = (k_q == K_LAST) && (mask_rem != '0);
            mask_d   = '0;
            k_d      = '0;
            state_d  = ST_IDLE;
          end
        end else begin
          // Only reachable for an empty snapshot: close it with no result.
          done_d   = 1'b1;
          nfound_d = 5'd0;
          k_d      = '0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and output registers; reset aborts any scan in progress without done_o.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      cnts_q     <= '0;
      pass_q     <= '0;
      k_q        <= '0;
      vpf_o      <= 1'b0;
      adr_o      <= ADR_INV;
      cnt_o      <= '0;
      idx_o      <= '0;
      done_o     <= 1'b0;
      nfound_o   <= '0;
      overflow_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cnts_q     <= cnts_d;
      pass_q     <= pass_d;
      k_q        <= k_d;
      vpf_o      <= vpf_d;
      adr_o      <= adr_d;
      cnt_o      <= cnt_d;
      idx_o      <= idx_d;
      done_o     <= done_d;
      nfound_o   <= nfound_d;
      overflow_o <= ovf_d;
    end
  end

  // The captured sideband is presented alongside every result of the snapshot.
  assign pass_o = pass_q;

endmodule

// File: tb/tb_priority_multi.sv
// Bench for priority_multi: directed vector table on a 192-pad/MXOUT=4 instance,
// hand sequences for back-to-back starts and mid-scan reset, and a model-checked 100-pad instance.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_priority_multi;

  logic clock;
  logic reset_n;

  // 192 pads, MXOUT = 4
  logic         start1;
  logic [2:0]   pass1;
  logic [191:0] vpfs1;
  logic [575:0] cnts1;
  logic         ready1, vpf1, done1, ovf1;
  logic [7:0]   adr1;
  logic [2:0]   cnt1, passo1;
  logic [3:0]   idx1;
  logic [4:0]   nf1;

  // 100 pads, MXOUT = 8
  logic         start2;
  logic [2:0]   pass2;
  logic [99:0]  vpfs2;
  logic [299:0] cnts2;
  logic         ready2, vpf2, done2, ovf2;
  logic [6:0]   adr2;
  logic [2:0]   cnt2, passo2;
  logic [3:0]   idx2;
  logic [4:0]   nf2;

  int checks = 0;
  int errors = 0;

  priority_multi #(.MXKEYS(192), .MXKEYBITS(8), .MXCNTB(3), .MXOUT(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .start_i(start1), .ready_o(ready1),
    .pass_i(pass1), .vpfs_i(vpfs1), .cnts_i(cnts1), .vpf_o(vpf1), .adr_o(adr1),
    .cnt_o(cnt1), .idx_o(idx1), .pass_o(passo1), .done_o(done1),
    .nfound_o(nf1), .overflow_o(ovf1)
  );

  priority_multi #(.MXKEYS(100), .MXKEYBITS(7), .MXCNTB(3), .MXOUT(8)) dut2 (
    .clock(clock), .reset_n(reset_n), .start_i(start2), .ready_o(ready2),
    .pass_i(pass2), .vpfs_i(vpfs2), .cnts_i(cnts2), .vpf_o(vpf2), .adr_o(adr2),
    .cnt_o(cnt2), .idx_o(idx2), .pass_o(passo2), .done_o(done2),
    .nfound_o(nf2), .overflow_o(ovf2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One directed snapshot: up to four pads (or all pads with cnt = i%8) and its expected results.
  typedef struct packed {
    logic [2:0]       np;
    logic [3:0][7:0]  pad;
    logic [3:0][2:0]  cn;
    logic             all;
    logic [2:0]       pass;
    logic [2:0]       en;
    logic [3:0][7:0]  eadr;
    logic [3:0][2:0]  ecnt;
    logic             eovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic apply1(input vec_t v);
    vpfs1 = '0;
    cnts1 = '0;
    if (v.all) begin
      for (int i = 0; i < 192; i++) begin
        vpfs1[i] = 1'b1;
        cnts1[i*3 +: 3] = 3'(i % 8);
      end
    end else begin
      for (int j = 0; j < int'(v.np); j++) begin
        vpfs1[v.pad[j]] = 1'b1;
        cnts1[int'(v.pad[j])*3 +: 3] = v.cn[j];
      end
    end
    pass1 = v.pass;
  endtask

  task automatic run1(input int vi, input vec_t v);
    int n;
    @(negedge clock);
    chk($sformatf("v%0d_ready_idle", vi), ready1, 1);
    apply1(v);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    chk($sformatf("v%0d_pass", vi), passo1, v.pass);
    chk($sformatf("v%0d_busy", vi), ready1, 0);
    n = (v.en == 0) ? 1 : int'(v.en);
    for (int r = 0; r < n; r++) begin
      @(negedge clock);
      if (v.en == 0) begin
        chk($sformatf("v%0d_empty_vpf", vi), vpf1, 0);
        chk($sformatf("v%0d_empty_adr", vi), adr1, 255);
        chk($sformatf("v%0d_empty_done", vi), done1, 1);
        chk($sformatf("v%0d_empty_nf", vi), nf1, 0);
        chk($sformatf("v%0d_empty_ovf", vi), ovf1, 0);
      end else begin
        chk($sformatf("v%0d_vpf%0d", vi, r), vpf1, 1);
        chk($sformatf("v%0d_adr%0d", vi, r), adr1, v.eadr[r]);
        chk($sformatf("v%0d_cnt%0d", vi, r), cnt1, v.ecnt[r]);
        chk($sformatf("v%0d_idx%0d", vi, r), idx1, r);
        chk($sformatf("v%0d_pass%0d", vi, r), passo1, v.pass);
        chk($sformatf("v%0d_done%0d", vi, r), done1, (r == n - 1) ? 1 : 0);
        if (r == n - 1) begin
          chk($sformatf("v%0d_nf", vi), nf1, v.en);
          chk($sformatf("v%0d_ovf", vi), ovf1, v.eovf);
        end
      end
    end
    @(negedge clock);
    chk($sformatf("v%0d_after_vpf", vi), vpf1, 0);
    chk($sformatf("v%0d_after_done", vi), done1, 0);
    chk($sformatf("v%0d_after_ovf", vi), ovf1, 0);
    chk($sformatf("v%0d_after_adr", vi), adr1, 255);
    chk($sformatf("v%0d_after_idx", vi), idx1, 0);
    chk($sformatf("v%0d_after_nf_hold", vi), nf1, v.en);
    chk($sformatf("v%0d_after_ready", vi), ready1, 1);
  endtask

  // Snapshot on the 100-pad instance, expectations from an in-order scan of the flags.
  task automatic run2(input string nm, input logic [99:0] v, input logic [299:0] c,
                      input logic [2:0] p);
    int eadr [8];
    int en;
    int n;
    logic eovf;
    en = 0;
    eovf = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (v[i]) begin
        if (en < 8) begin
          eadr[en] = i;
          en++;
        end else begin
          eovf = 1'b1;
        end
      end
    end
    @(negedge clock);
    chk({nm, "_ready"}, ready2, 1);
    vpfs2 = v;
    cnts2 = c;
    pass2 = p;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    n = (en == 0) ? 1 : en;
    for (int r = 0; r < n; r++) begin
      @(negedge clock);
      if (en == 0) begin
        chk({nm, "_empty_vpf"}, vpf2, 0);
        chk({nm, "_empty_adr"}, adr2, 127);
        chk({nm, "_empty_done"}, done2, 1);
        chk({nm, "_empty_nf"}, nf2, 0);
      end else begin
        chk($sformatf("%s_vpf%0d", nm, r), vpf2, 1);
        chk($sformatf("%s_adr%0d", nm, r), adr2, eadr[r]);
        chk($sformatf("%s_cnt%0d", nm, r), cnt2, c[eadr[r]*3 +: 3]);
        chk($sformatf("%s_idx%0d", nm, r), idx2, r);
        chk($sformatf("%s_pass%0d", nm, r), passo2, p);
        chk($sformatf("%s_done%0d", nm, r), done2, (r == n - 1) ? 1 : 0);
        if (r == n - 1) begin
          chk({nm, "_nf"}, nf2, en);
          chk({nm, "_ovf"}, ovf2, eovf);
        end
      end
    end
    @(negedge clock);
    chk({nm, "_after_vpf"}, vpf2, 0);
    chk({nm, "_after_ready"}, ready2, 1);
  endtask

  initial begin
    vec_t a, b, c;
    logic [99:0]  rv;
    logic [299:0] rc;

    // np, pads{3,2,1,0}, cnts{3,2,1,0}, all, pass, en, eadr{3..0}, ecnt{3..0}, eovf
    tbl[0] = '{3'd3, {8'd0, 8'd191, 8'd17, 8'd5}, {3'd0, 3'd1, 3'd7, 3'd2}, 1'b0, 3'd3,
               3'd3, {8'd0, 8'd191, 8'd17, 8'd5}, {3'd0, 3'd1, 3'd7, 3'd2}, 1'b0};
    tbl[1] = '{3'd0, 32'd0, 12'd0, 1'b1, 3'd5,
               3'd4, {8'd3, 8'd2, 8'd1, 8'd0}, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b1};
    tbl[2] = '{3'd0, 32'd0, 12'd0, 1'b0, 3'd1,
               3'd0, 32'd0, 12'd0, 1'b0};
    tbl[3] = '{3'd3, {8'd0, 8'd2, 8'd1, 8'd0}, {3'd0, 3'd6, 3'd5, 3'd4}, 1'b0, 3'd7,
               3'd3, {8'd0, 8'd2, 8'd1, 8'd0}, {3'd0, 3'd6, 3'd5, 3'd4}, 1'b0};
    tbl[4] = '{3'd1, {8'd0, 8'd0, 8'd0, 8'd191}, {3'd0, 3'd0, 3'd0, 3'd3}, 1'b0, 3'd2,
               3'd1, {8'd0, 8'd0, 8'd0, 8'd191}, {3'd0, 3'd0, 3'd0, 3'd3}, 1'b0};
    tbl[5] = '{3'd3, {8'd0, 8'd0, 8'd191, 8'd190}, {3'd0, 3'd3, 3'd2, 3'd1}, 1'b0, 3'd4,
               3'd3, {8'd0, 8'd191, 8'd190, 8'd0}, {3'd0, 3'd2, 3'd1, 3'd3}, 1'b0};
    tbl[6] = '{3'd4, {8'd40, 8'd30, 8'd20, 8'd10}, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 3'd6,
               3'd4, {8'd40, 8'd30, 8'd20, 8'd10}, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0};
    tbl[7] = '{3'd4, {8'd191, 8'd150, 8'd3, 8'd100}, {3'd7, 3'd6, 3'd5, 3'd4}, 1'b0, 3'd0,
               3'd4, {8'd191, 8'd150, 8'd100, 8'd3}, {3'd7, 3'd6, 3'd4, 3'd5}, 1'b0};

    reset_n = 1'b0;
    start1 = 1'b0; pass1 = '0; vpfs1 = '0; cnts1 = '0;
    start2 = 1'b0; pass2 = '0; vpfs2 = '0; cnts2 = '0;

    // Values held during reset
    #12;
    chk("rst_ready", ready1, 1);
    chk("rst_vpf", vpf1, 0);
    chk("rst_adr", adr1, 255);
    chk("rst_cnt", cnt1, 0);
    chk("rst_done", done1, 0);
    chk("rst_nf", nf1, 0);
    chk("rst_pass", passo1, 0);
    chk("rst_adr2", adr2, 127);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run1(i, tbl[i]);
    end

    // Back-to-back: start held high across three snapshots, next data presented early.
    a = tbl[0]; b = tbl[2]; c = tbl[4];
    @(negedge clock);
    apply1(a);
    start1 = 1'b1;
    @(negedge clock);
    chk("b2b_passA", passo1, a.pass);
    chk("b2b_busyA", ready1, 0);
    apply1(b);
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      chk($sformatf("b2b_A_vpf%0d", r), vpf1, 1);
      chk($sformatf("b2b_A_adr%0d", r), adr1, a.eadr[r]);
      chk($sformatf("b2b_A_pass%0d", r), passo1, a.pass);
      chk($sformatf("b2b_A_done%0d", r), done1, (r == 2) ? 1 : 0);
      chk($sformatf("b2b_A_ready%0d", r), ready1, (r == 2) ? 1 : 0);
    end
    @(negedge clock);
    chk("b2b_passB", passo1, b.pass);
    chk("b2b_busyB", ready1, 0);
    chk("b2b_B_novpf", vpf1, 0);
    apply1(c);
    @(negedge clock);
    chk("b2b_B_done", done1, 1);
    chk("b2b_B_vpf", vpf1, 0);
    chk("b2b_B_nf", nf1, 0);
    chk("b2b_B_ready", ready1, 1);
    @(negedge clock);
    start1 = 1'b0;
    chk("b2b_passC", passo1, c.pass);
    chk("b2b_busyC", ready1, 0);
    @(negedge clock);
    chk("b2b_C_vpf", vpf1, 1);
    chk("b2b_C_adr", adr1, 191);
    chk("b2b_C_done", done1, 1);
    chk("b2b_C_nf", nf1, 1);
    @(negedge clock);
    chk("b2b_C_idle", ready1, 1);
    chk("b2b_C_after_vpf", vpf1, 0);

    // Reset after the first result of a 3-pad snapshot.
    apply1(tbl[0]);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    @(negedge clock);
    chk("mrst_first_vpf", vpf1, 1);
    chk("mrst_first_adr", adr1, 5);
    reset_n = 1'b0;
    #1;
    chk("mrst_vpf", vpf1, 0);
    chk("mrst_adr", adr1, 255);
    chk("mrst_cnt", cnt1, 0);
    chk("mrst_idx", idx1, 0);
    chk("mrst_pass", passo1, 0);
    chk("mrst_done", done1, 0);
    chk("mrst_nf", nf1, 0);
    chk("mrst_ready", ready1, 1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      chk($sformatf("mrst_nodone%0d", r), done1, 0);
      chk($sformatf("mrst_novpf%0d", r), vpf1, 0);
      chk($sformatf("mrst_ready%0d", r), ready1, 1);
    end
    run1(10, tbl[3]);

    // 100-pad instance: top pad alone, then random snapshots (sparse and dense).
    rv = '0; rc = '0;
    rv[99] = 1'b1;
    rc[297 +: 3] = 3'd5;
    run2("k100_bit99", rv, rc, 3'd3);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 100; i++) begin
        rv[i] = (t % 2 == 0) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
        rc[i*3 +: 3] = 3'($urandom_range(0, 7));
      end
      run2($sformatf("k100_rnd%0d", t), rv, rc, 3'($urandom_range(0, 7)));
    end
    run2("k100_empty", '0, rc, 3'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
